mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIM, 3, consecutive fetch losses before fetch is forced to win.
- TIMEOUT, 15, maximum wait cycles for mem_ready.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, asynchronous active-low reset.
- if_req, in, 1, fetch read request; held until if_ack.
- if_addr, in, AW, fetch address.
- if_ack, out, 1, one-cycle fetch completion pulse.
- if_rdata, out, DW, fetch read data; valid with if_ack.
- dm_req, in, 1, data-memory request; held until dm_ack.
- dm_we, in, 1, 1 = write, 0 = read.
- dm_addr, in, AW, data address.
- dm_wdata, in, DW, write data.
- dm_ack, out, 1, one-cycle data completion pulse.
- dm_rdata, out, DW, data read data; valid with dm_ack.
- mem_req, out, 1, shared-port request.
- mem_we, out, 1, shared-port write enable.
- mem_addr, out, AW, shared-port address.
- mem_wdata, out, DW, shared-port write data.
- mem_rdata, in, DW, shared-port read data.
- mem_ready, in, 1, shared-port access complete this cycle.
- stall_f, out, 1, stall Fetch/Decode: if_req high and no if_ack this cycle.
- stall_m, out, 1, stall Memory stage: dm_req high and no dm_ack this cycle.
- timeout_err, out, 1, sticky: an access exceeded TIMEOUT.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, BUSY_IF, BUSY_DM, RESP.
REQ-004 if_req and dm_req SHALL be sampled only in IDLE; in every other state they are ignored.
REQ-005 IDLE SHALL transition as follows:
- Only if_req high: go to BUSY_IF.
- Only dm_req high: go to BUSY_DM.
- Both high: go to BUSY_DM, unless starve_cnt == STARVE_LIM, in which case go to BUSY_IF.
- Neither high: stay in IDLE.
REQ-006 On the IDLE exit edge, the arbiter SHALL latch the granted requester's addr/we/wdata; mem_addr, mem_we and mem_wdata SHALL be driven only from these latches. Fetch grants SHALL latch we = 0.
REQ-007 mem_req SHALL be 1 exactly in BUSY_IF and BUSY_DM, and 0 in IDLE and RESP.
REQ-008 In BUSY_IF and BUSY_DM, a cycle with mem_ready = 1 SHALL:
- capture mem_rdata into the response register;
- go to RESP.
REQ-009 In RESP, the arbiter SHALL, for exactly one cycle:
- assert if_ack or dm_ack according to the grant;
- present the captured data on if_rdata or dm_rdata;
- then go to IDLE.
REQ-010 The minimum access latency SHALL be 3 cycles from req sampled in IDLE to ack; back-to-back throughput SHALL be one access per 3 cycles when mem_ready is immediate.
REQ-011 Requesters SHALL drop or change req in the cycle after ack; because IDLE always follows RESP, a held req is re-sampled as a new request.
REQ-012 starve_cnt SHALL saturate at STARVE_LIM and update as follows:
- increments when both requests are present and dm wins;
- clears on every fetch grant;
- otherwise holds.
REQ-013 A wait counter SHALL clear on entering a BUSY state and increment each BUSY cycle without mem_ready. When it reaches TIMEOUT the arbiter SHALL:
- set timeout_err;
- go to RESP with rdata = 0.
REQ-014 timeout_err SHALL stay set until reset.
REQ-015 if_rdata and dm_rdata SHALL hold their last value outside RESP.

Reset
REQ-016 Asserting rst low SHALL immediately, including mid-access:
- force IDLE;
- drive mem_req, mem_we, if_ack, dm_ack and timeout_err to 0;
- clear starve_cnt, the wait counter, the latches and the rdata registers to 0.
REQ-017 An access interrupted by reset SHALL never produce an ack.
REQ-018 After rst rises, the first request SHALL be sampled on the next rising edge in IDLE.

Structure
REQ-019 The state encoding (2-bit localparams IDLE=0, BUSY_IF=1, BUSY_DM=2, RESP=3) and the default AW/DW SHALL reside in the shared pipeline package.
REQ-020 The block SHALL be flat, except for one optional sub-module, arb_wait_counter, implementing the saturating wait/starve counter.
REQ-021 The block SHALL be instantiated in pipeline_top between the Fetch/Memory stages and a single unified memory.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single fetch: if_req=1, if_addr=0x10, mem_ready on first BUSY cycle, mem_rdata=0x00500093 -> if_ack on cycle 3 with if_rdata=0x00500093; mem_we=0 throughout.
- Collision: if_req and dm_req both held continuously, dm_we=1, dm_addr=0x80, dm_wdata=0xDEADBEEF, immediate mem_ready -> grant order DM, DM, DM, IF; starve_cnt returns to 0 after the IF grant.
- Wait states: mem_ready delayed 4 cycles -> mem_req and mem_addr stable for 5 BUSY cycles; stall_m=1 until the dm_ack cycle.
- Timeout: mem_ready never asserted -> timeout_err=1 after 15 BUSY cycles; ack with rdata=0; timeout_err still 1 in later accesses.
- Reset mid-access: rst low during BUSY_DM -> mem_req=0 and no dm_ack; after release, a new if_req is serviced normally.
- Idle: no requests for 10 cycles -> mem_req=0, stall_f=0, stall_m=0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_DM = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    BUSY_IF = ST_BUSY_IF,
    BUSY_DM = ST_BUSY_DM,
    RESP    = ST_RESP
  } arb_state_e;

  // Bits needed to count from 0 up to lim inclusive.
  function automatic int cnt_width(input int lim);
    return (lim < 2) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Saturating up-counter with synchronous clear; used for both the
// access wait count and the fetch starvation count.
module arb_wait_counter #(
  parameter int W   = 4,
  parameter int LIM = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] LIM_V = W'(LIM);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops at LIM.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIM_V)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data-memory requesters onto one shared memory
// port. Data wins collisions unless fetch has lost STARVE_LIM times in a row.
//
// state   | meaning
// IDLE    | sample requests, latch the winner's access
// BUSY_IF | fetch access on the shared port, waiting for mem_ready
// BUSY_DM | data access on the shared port, waiting for mem_ready
// RESP    | one-cycle ack with captured read data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_LIM = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_f,
  output logic          stall_m,
  output logic          timeout_err
);

  localparam int SW = cnt_width(STARVE_LIM);
  localparam int WW = cnt_width(TIMEOUT);
  localparam logic [SW-1:0] STARVE_V  = SW'(STARVE_LIM);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic          grant_dm_q, grant_dm_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          err_q, err_d;

  logic          st_clr, st_inc, wt_clr, wt_inc;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;

  arb_wait_counter #(.W(SW), .LIM(STARVE_LIM)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .clr_i (st_clr),
    .inc_i (st_inc),
    .cnt_o (starve_cnt)
  );

  arb_wait_counter #(.W(WW), .LIM(TIMEOUT)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clr_i (wt_clr),
    .inc_i (wt_inc),
    .cnt_o (wait_cnt)
  );

  // Next-state, access latching, read-data capture and counter control.
  always_comb begin
    state_d    = state_q;
    grant_dm_d = grant_dm_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = err_q;
    st_clr     = 1'b0;
    st_inc     = 1'b0;
    wt_clr     = 1'b0;
    wt_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dm_req && !(if_req && (starve_cnt == STARVE_V))) begin
          state_d    = BUSY_DM;
          grant_dm_d = 1'b1;
          addr_d     = dm_addr;
          we_d       = dm_we;
          wdata_d    = dm_wdata;
          wt_clr     = 1'b1;
          st_inc     = if_req;
        end else if (if_req) begin
          state_d    = BUSY_IF;
          grant_dm_d = 1'b0;
          addr_d     = if_addr;
          we_d       = 1'b0;
          wdata_d    = '0;
          wt_clr     = 1'b1;
          st_clr     = 1'b1;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready) begin
          state_d = RESP;
          if (grant_dm_q) dm_rdata_d = mem_rdata;
          else            if_rdata_d = mem_rdata;
        end else begin
          wt_inc = 1'b1;
          // This cycle brings the wait count to TIMEOUT: abandon the access.
          if (wait_cnt == WAIT_LAST) begin
            state_d = RESP;
            err_d   = 1'b1;
            if (grant_dm_q) dm_rdata_d = '0;
            else            if_rdata_d = '0;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched access and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_dm_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_dm_q <= grant_dm_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
    end
  end

  assign mem_req     = (state_q == BUSY_IF) || (state_q == BUSY_DM);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign if_ack      = (state_q == RESP) && !grant_dm_q;
  assign dm_ack      = (state_q == RESP) && grant_dm_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign stall_f     = if_req && !if_ack;
  assign stall_m     = dm_req && !dm_ack;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small delayed-ready memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        stall_f;
  logic        stall_m;
  logic        timeout_err;

  int n_vec = 0;
  int n_bad = 0;
  int rdy_delay = 0;
  int busy_n = 0;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ack     (if_ack),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_ack     (dm_ack),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .stall_f    (stall_f),
    .stall_m    (stall_m),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Memory model: ready on the (rdy_delay+1)-th consecutive BUSY cycle.
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ready = (busy_n == rdy_delay);
      busy_n    = busy_n + 1;
    end else begin
      mem_ready = 1'b0;
      busy_n    = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called just after the edge that starts the request cycle (cycle 1).
  task automatic run_acc(input int max_cyc, output int lat, output bit got_if, output bit got_dm);
    lat = 0;
    got_if = 1'b0;
    got_dm = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (if_ack || dm_ack) begin
        lat    = c;
        got_if = if_ack;
        got_dm = dm_ack;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit gi, gd;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mreq",  mem_req, 0);
    chk("rst_mwe",   mem_we, 0);
    chk("rst_ifack", if_ack, 0);
    chk("rst_dmack", dm_ack, 0);
    chk("rst_terr",  timeout_err, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_ifrd",  if_rdata, 0);
    chk("rst_dmrd",  dm_rdata, 0);

    // single fetch, request presented together with reset release
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h00500093; rdy_delay = 0;
    @(negedge clk);
    chk("f1_mreq", mem_req, 0);
    chk("f1_stallf", stall_f, 1);
    chk("f1_mwe", mem_we, 0);
    next_cyc();
    @(negedge clk);
    chk("f2_mreq", mem_req, 1);
    chk("f2_addr", mem_addr, 32'h10);
    chk("f2_mwe", mem_we, 0);
    chk("f2_ack", if_ack, 0);
    next_cyc();
    @(negedge clk);
    chk("f3_ack", if_ack, 1);
    chk("f3_rdata", if_rdata, 32'h00500093);
    chk("f3_stallf", stall_f, 0);
    chk("f3_mreq", mem_req, 0);
    chk("f3_mwe", mem_we, 0);
    next_cyc();
    if_req = 1'b0;
    @(negedge clk);
    chk("f4_ack", if_ack, 0);
    chk("f4_hold", if_rdata, 32'h00500093);
    next_cyc();

    // collision: both held, expected DM,DM,DM,IF twice
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEADBEEF;
    mem_rdata = 32'h0; rdy_delay = 0;
    for (int g = 0; g < 8; g++) begin
      bit exp_if;
      exp_if = ((g % 4) == 3);
      run_acc(10, lat, gi, gd);
      chk($sformatf("col%0d_lat", g), lat, 3);
      chk($sformatf("col%0d_ifack", g), {31'b0, gi}, {31'b0, exp_if});
      chk($sformatf("col%0d_dmack", g), {31'b0, gd}, {31'b0, !exp_if});
      chk($sformatf("col%0d_addr", g), mem_addr, exp_if ? 32'h40 : 32'h80);
      chk($sformatf("col%0d_mwe", g), mem_we, exp_if ? 32'd0 : 32'd1);
      if (!exp_if) chk($sformatf("col%0d_wdata", g), mem_wdata, 32'hDEADBEEF);
      next_cyc();
    end

    // wait states: ready on the 5th BUSY cycle
    if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h120; mem_rdata = 32'hCAFEF00D; rdy_delay = 4;
    @(negedge clk);
    chk("w_idle_mreq", mem_req, 0);
    chk("w_idle_stallm", stall_m, 1);
    for (int c = 0; c < 5; c++) begin
      next_cyc();
      @(negedge clk);
      chk($sformatf("w_b%0d_mreq", c), mem_req, 1);
      chk($sformatf("w_b%0d_addr", c), mem_addr, 32'h120);
      chk($sformatf("w_b%0d_stallm", c), stall_m, 1);
      chk($sformatf("w_b%0d_ack", c), dm_ack, 0);
    end
    next_cyc();
    @(negedge clk);
    chk("w_ack", dm_ack, 1);
    chk("w_rdata", dm_rdata, 32'hCAFEF00D);
    chk("w_stallm", stall_m, 0);
    chk("w_terr", timeout_err, 0);
    next_cyc();

    // timeout: 15 BUSY cycles then ack with zero data
    dm_addr = 32'h200; mem_rdata = 32'h12345678; rdy_delay = 1000;
    run_acc(30, lat, gi, gd);
    chk("to_lat", lat, 17);
    chk("to_dmack", {31'b0, gd}, 1);
    chk("to_rdata", dm_rdata, 0);
    chk("to_terr", timeout_err, 1);
    next_cyc();

    // later access: error stays sticky, dm_rdata holds
    dm_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h44; mem_rdata = 32'h0000AAAA; rdy_delay = 0;
    run_acc(10, lat, gi, gd);
    chk("post_lat", lat, 3);
    chk("post_ifack", {31'b0, gi}, 1);
    chk("post_rdata", if_rdata, 32'h0000AAAA);
    chk("post_terr", timeout_err, 1);
    chk("post_dmhold", dm_rdata, 0);
    next_cyc();

    // reset during BUSY_DM
    if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'h55AA55AA; rdy_delay = 1000;
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    chk("rm_busy_mreq", mem_req, 1);
    chk("rm_busy_mwe", mem_we, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rm_mreq", mem_req, 0);
    chk("rm_mwe", mem_we, 0);
    chk("rm_dmack", dm_ack, 0);
    chk("rm_terr", timeout_err, 0);
    chk("rm_addr", mem_addr, 0);
    chk("rm_ifrd", if_rdata, 0);
    dm_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rm_hold%0d_dmack", c), dm_ack, 0);
    end
    next_cyc();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h50; mem_rdata = 32'h11112222; rdy_delay = 0;
    run_acc(10, lat, gi, gd);
    chk("rr_lat", lat, 3);
    chk("rr_ifack", {31'b0, gi}, 1);
    chk("rr_dmack", {31'b0, gd}, 0);
    chk("rr_rdata", if_rdata, 32'h11112222);
    next_cyc();
    if_req = 1'b0;

    // idle: nothing requested for 10 cycles
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_mreq", c), mem_req, 0);
      chk($sformatf("idle%0d_stallf", c), stall_f, 0);
      chk($sformatf("idle%0d_stallm", c), stall_m, 0);
      next_cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
